// File: rtl/half_adder.sv
// half_adder: WIDTH-lane half adder with a registered copy and a saturating carry-event counter.
// Define HALF_ADDER_CHECK_EN to add the sticky check_err output and its self-checking logic.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
`ifdef HALF_ADDER_CHECK_EN
    output logic             check_err,
`endif
    output logic [CNT_W-1:0] carry_count
);
    logic [WIDTH-1:0] sum_d, carry_d;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign sum         = a ^ b;
    assign carry       = a & b;
    assign out_valid   = valid_q;
    assign carry_count = cnt_q;

    always_comb begin
        sum_d   = in_valid ? sum : sum_q;
        carry_d = in_valid ? carry : carry_q;
        valid_d = in_valid;
        cnt_d   = (in_valid && |carry && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HALF_ADDER_CHECK_EN
    // Independent reference copies so a corrupted result register is caught.
    logic [WIDTH-1:0] ref_sum_d, ref_sum_q, ref_carry_d, ref_carry_q;
    logic             err_d, err_q;

    assign check_err = err_q;

    always_comb begin
        ref_sum_d   = in_valid ? (a ^ b) : ref_sum_q;
        ref_carry_d = in_valid ? (a & b) : ref_carry_q;
        err_d       = err_q | (valid_q & ((sum_q != ref_sum_q) | (carry_q != ref_carry_q) | (|(sum_q & carry_q))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_sum_q   <= '0;
            ref_carry_q <= '0;
            err_q       <= 1'b0;
        end else begin
            ref_sum_q   <= ref_sum_d;
            ref_carry_q <= ref_carry_d;
            err_q       <= err_d;
        end
    end

`ifndef SYNTHESIS
    always @* begin
        assert (sum === (a ^ b)) else $error("corrupt sum");
        assert (carry === (a & b)) else $error("corrupt carry");
    end
`endif
`endif
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed checks of a scalar instance and a 4-lane instance with a 2-bit counter.
module tb_half_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       s1, c1, sq1, cq1, ov1;
    logic [15:0] cnt1;
    logic [3:0] a4 = '0, b4 = '0, s4, c4, sq4, cq4;
    logic       v4 = 1'b0, ov4;
    logic [1:0] cnt4;
    int         total = 0;
    int         bad = 0;
`ifdef HALF_ADDER_CHECK_EN
    logic       err1, err4;
`endif

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1),
`ifdef HALF_ADDER_CHECK_EN
        .check_err(err1),
`endif
        .carry_count(cnt1)
    );

    half_adder #(.WIDTH(4), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
        .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4),
`ifdef HALF_ADDER_CHECK_EN
        .check_err(err4),
`endif
        .carry_count(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic edge_s();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ab;
        logic [1:0] exp_s = 2'b00, exp_c = 2'b00;
        // Exhaustive scalar truth table: b toggles every unit, a every two.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            {a1, b1} = ab;
            #0;
            exp_s = (i == 1 || i == 2) ? 2'b01 : 2'b00;
            exp_c = (i == 3) ? 2'b01 : 2'b00;
            chk("sweep_sum", {31'b0, s1}, {30'b0, exp_s});
            chk("sweep_carry", {31'b0, c1}, {30'b0, exp_c});
            #1;
        end
        edge_s();
        chk("rst_sum_q", {31'b0, sq1}, 0);
        chk("rst_carry_q", {31'b0, cq1}, 0);
        chk("rst_out_valid", {31'b0, ov1}, 0);
        chk("rst_count", {16'b0, cnt1}, 0);
        chk("rst_count4", {30'b0, cnt4}, 0);
        rst = 1'b0; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        edge_s();
        chk("lat_sum_q", {31'b0, sq1}, 0);
        chk("lat_carry_q", {31'b0, cq1}, 1);
        chk("lat_out_valid", {31'b0, ov1}, 1);
        chk("lat_count", {16'b0, cnt1}, 1);
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        #0;
        chk("hold_comb_sum", {31'b0, s1}, 1);
        edge_s();
        chk("hold_sum_q", {31'b0, sq1}, 0);
        chk("hold_carry_q", {31'b0, cq1}, 1);
        chk("hold_out_valid", {31'b0, ov1}, 0);
        chk("hold_count", {16'b0, cnt1}, 1);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        edge_s();
        chk("nocarry_sum_q", {31'b0, sq1}, 1);
        chk("nocarry_carry_q", {31'b0, cq1}, 0);
        chk("nocarry_count", {16'b0, cnt1}, 1);
        v1 = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010;
        #0;
        chk("lanes_sum", {28'b0, s4}, 32'h6);
        chk("lanes_carry", {28'b0, c4}, 32'h8);
        a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b1;
        edge_s();
        chk("sat1", {30'b0, cnt4}, 1);
        chk("sat_carry_q", {28'b0, cq4}, 32'hf);
        chk("sat_sum_q", {28'b0, sq4}, 0);
        edge_s();
        chk("sat2", {30'b0, cnt4}, 2);
        edge_s();
        chk("sat3", {30'b0, cnt4}, 3);
        edge_s();
        chk("sat4", {30'b0, cnt4}, 3);
        edge_s();
        chk("sat5", {30'b0, cnt4}, 3);
        chk("sat_out_valid", {31'b0, ov4}, 1);
        rst = 1'b1;
        a4 = 4'b0110; b4 = 4'b0011;
        #0;
        chk("rst_comb_sum", {28'b0, s4}, 32'h5);
        chk("rst_comb_carry", {28'b0, c4}, 32'h2);
        edge_s();
        chk("midrst_count", {30'b0, cnt4}, 0);
        chk("midrst_out_valid", {31'b0, ov4}, 0);
        chk("midrst_carry_q", {28'b0, cq4}, 0);
        rst = 1'b0;
        edge_s();
        chk("post_rst_count", {30'b0, cnt4}, 1);
        chk("post_rst_sum_q", {28'b0, sq4}, 32'h5);
        v4 = 1'b0;
`ifdef HALF_ADDER_CHECK_EN
        v1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a1 = 1'($urandom_range(1));
            b1 = 1'($urandom_range(1));
            edge_s();
        end
        chk("rand_check_err", {31'b0, err1}, 0);
        a1 = 1'b1; b1 = 1'b0;
        edge_s();
        force u1.sum_q = 1'b0;
        edge_s();
        release u1.sum_q;
        edge_s();
        chk("forced_err", {31'b0, err1}, 1);
        edge_s();
        chk("sticky_err", {31'b0, err1}, 1);
        rst = 1'b1;
        edge_s();
        chk("err_cleared", {31'b0, err1}, 0);
        rst = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
